// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI byte receiver slice.
package spi_pkg;

    localparam int SPI_BITS    = 8;
    localparam int SYNC_STAGES = 2;

    typedef enum logic {
        IDLE,
        SHIFT
    } rxState_t;

endpackage

// File: rtl/spi_byte_receiver_if.sv
// Pin-level SPI input, FIFO read handshake, latch output and error flags of the receiver.
interface spi_byte_receiver_if;

    logic                         sck;
    logic                         mosi;
    logic                         load;
    logic [spi_pkg::SPI_BITS-1:0] rd_data;
    logic                         rd_valid;
    logic                         rd_ready;
    logic [spi_pkg::SPI_BITS-1:0] out_q;
    logic                         out_strobe;
    logic                         overrun;
    logic                         frame_err;
    logic                         err_clr;

    modport slave (
        input  sck, mosi, load, rd_ready, err_clr,
        output rd_data, rd_valid, out_q, out_strobe, overrun, frame_err
    );

    modport master (
        output sck, mosi, load, rd_ready, err_clr,
        input  rd_data, rd_valid, out_q, out_strobe, overrun, frame_err
    );

endinterface

// File: rtl/sync_fifo.sv
// Register-based first-word-fall-through FIFO; pointers carry an extra wrap bit for full/empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic             doPush;
    logic             doPop;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPop   = pop_i & ~empty_o;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign doPush  = push_i & (~full_o | doPop);
    assign rdata_o = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q[AW-1:0]] <= wdata_i;
                wrPtr_q                <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_byte_receiver.sv
// Oversampling SPI target: MSB-first byte deserialiser feeding a FIFO, with a 595-style
// output latch on load and sticky overrun/framing flags.
module spi_byte_receiver
    import spi_pkg::*;
#(
    parameter int                  FIFO_DEPTH  = 4,
    parameter bit                  INVERT_MOSI = 1'b1,
    parameter logic [SPI_BITS-1:0] OUT_RESET   = 8'h00
) (
    input logic                 clk,
    input logic                 rst_n,
    spi_byte_receiver_if.slave  bus
);

    localparam int            CW   = $clog2(SPI_BITS);
    localparam logic [CW-1:0] LAST = CW'(SPI_BITS - 1);

    logic [SYNC_STAGES:0]   sckSync_q;
    logic [SYNC_STAGES:0]   loadSync_q;
    logic [SYNC_STAGES-1:0] mosiSync_q;

    rxState_t            state_q,     state_d;
    logic [CW-1:0]       bitCnt_q,    bitCnt_d;
    logic [SPI_BITS-1:0] shreg_q,     shreg_d;
    logic [SPI_BITS-1:0] lastByte_q,  lastByte_d;
    logic [SPI_BITS-1:0] outQ_q,      outQ_d;
    logic                outStrobe_q, outStrobe_d;
    logic                overrun_q,   overrun_d;
    logic                frameErr_q,  frameErr_d;

    logic                sckRise;
    logic                loadRise;
    logic                rxBit;
    logic                push;
    logic                fifoFull;
    logic                fifoEmpty;
    logic [CW-1:0]       cntWork;
    logic [SPI_BITS-1:0] shWork;

    assign sckRise  = sckSync_q[SYNC_STAGES-1]  & ~sckSync_q[SYNC_STAGES];
    assign loadRise = loadSync_q[SYNC_STAGES-1] & ~loadSync_q[SYNC_STAGES];
    assign rxBit    = mosiSync_q[SYNC_STAGES-1] ^ INVERT_MOSI;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sckSync_q   <= '0;
            loadSync_q  <= '0;
            mosiSync_q  <= '0;
            state_q     <= IDLE;
            bitCnt_q    <= '0;
            shreg_q     <= '0;
            lastByte_q  <= '0;
            outQ_q      <= OUT_RESET;
            outStrobe_q <= 1'b0;
            overrun_q   <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            sckSync_q   <= {sckSync_q[SYNC_STAGES-1:0],  bus.sck};
            loadSync_q  <= {loadSync_q[SYNC_STAGES-1:0], bus.load};
            mosiSync_q  <= {mosiSync_q[SYNC_STAGES-2:0], bus.mosi};
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shreg_q     <= shreg_d;
            lastByte_q  <= lastByte_d;
            outQ_q      <= outQ_d;
            outStrobe_q <= outStrobe_d;
            overrun_q   <= overrun_d;
            frameErr_q  <= frameErr_d;
        end
    end

    // Load is resolved before the sck bit, except that a completing 8th bit beats the load.
    always_comb begin
        lastByte_d  = lastByte_q;
        outQ_d      = outQ_q;
        outStrobe_d = 1'b0;
        frameErr_d  = frameErr_q & ~bus.err_clr;
        overrun_d   = overrun_q & ~bus.err_clr;
        push        = 1'b0;
        cntWork     = bitCnt_q;
        shWork      = shreg_q;

        if (loadRise && (state_q == SHIFT) && !(sckRise && (bitCnt_q == LAST))) begin
            frameErr_d = 1'b1;
            cntWork    = '0;
            shWork     = '0;
        end

        shreg_d  = shWork;
        bitCnt_d = cntWork;
        if (sckRise) begin
            shreg_d = {shWork[SPI_BITS-2:0], rxBit};
            if (cntWork == LAST) begin
                push       = 1'b1;
                lastByte_d = shreg_d;
                bitCnt_d   = '0;
            end else begin
                bitCnt_d = cntWork + 1'b1;
            end
        end

        if (loadRise) begin
            outQ_d      = lastByte_d;
            outStrobe_d = 1'b1;
        end

        if (push && fifoFull && !bus.rd_ready) begin
            overrun_d = 1'b1;
        end

        state_d = (bitCnt_d == '0) ? IDLE : SHIFT;
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SPI_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (bus.rd_ready),
        .wdata_i (shreg_d),
        .rdata_o (bus.rd_data),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign bus.rd_valid   = ~fifoEmpty;
    assign bus.out_q      = outQ_q;
    assign bus.out_strobe = outStrobe_q;
    assign bus.overrun    = overrun_q;
    assign bus.frame_err  = frameErr_q;

endmodule
